// File: rtl/fp_divsqrt_iter.sv
// ---------------------------------------------------------------------------
// fp_divsqrt_iter
//   Iterative significand engine for the FPU divide / square-root path.
//   Restoring radix-2 division (a/b) and square root (of a, optionally
//   doubled for odd exponents), retiring BITS_PER_CYCLE result bits per
//   clock. Exponent, sign, special values and rounding live in the
//   enclosing FP unit; this block only produces {int, fraction, guard,
//   round} plus sticky.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start / ready    request handshake; start accepted when ready=1
//   mode_sqrt        0 = divide a/b, 1 = sqrt(a)
//   expo_odd         sqrt only: radicand is doubled
//   bypass           complete in one cycle without iterating
//   id_in / id_out   tag carried from accept to result
//   a, b             normalised significands, hidden bit set
//   flush            abort any in-flight or completed operation
//   done / ack       result valid (held) / consumer takes it
//   result           {int bit, FRAC_W fraction, guard, round}
//   sticky           remainder nonzero
//   bypassed         result came from a bypass request (result/sticky = 0)
// ---------------------------------------------------------------------------
module fp_divsqrt_iter #(
    parameter int FRAC_W         = 52,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ID_W           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic              mode_sqrt,
    input  logic              expo_odd,
    input  logic              bypass,
    input  logic [ID_W-1:0]   id_in,
    input  logic [FRAC_W:0]   a,
    input  logic [FRAC_W:0]   b,
    input  logic              flush,
    output logic              done,
    input  logic              ack,
    output logic [ID_W-1:0]   id_out,
    output logic [FRAC_W+2:0] result,
    output logic              sticky,
    output logic              bypassed
);

    localparam int W     = FRAC_W + 1;
    localparam int RES_W = FRAC_W + 3;
    localparam int ITERS = (RES_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    // Bits of the first group that lie above the result MSB; they are run
    // as no-op leading steps so the last group ends exactly on the LSB.
    localparam int EXC   = ITERS * BITS_PER_CYCLE - RES_W;
    // Shared partial remainder: sqrt needs FRAC_W+6, divide needs only W+2.
    localparam int REM_W = FRAC_W + 6;
    localparam int X_W   = 2 * RES_W;
    localparam int CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REM_W-1:0]   rem_q;
    logic [X_W-1:0]     x_q;      // radicand, consumed two bits per sqrt step
    logic [W-1:0]       dvs_q;
    logic [RES_W-1:0]   quo_q;
    logic               sqrt_q;
    logic [ID_W-1:0]    id_q;

    logic               accept;
    logic               first_grp;
    logic [REM_W-1:0]   dvs_ext;
    logic [REM_W-1:0]   rem_n;
    logic [X_W-1:0]     x_n;
    logic [RES_W-1:0]   quo_n;
    logic [REM_W-1:0]   r_sh;
    logic [REM_W-1:0]   trial;
    logic [REM_W-1:0]   diff;
    logic               bit_q;

    assign ready     = (state == S_IDLE) || (state == S_DONE && ack);
    assign accept    = start && ready;
    assign first_grp = (cnt == CNT_W'(ITERS));
    assign dvs_ext   = {{(REM_W-W){1'b0}}, dvs_q};

    // One clock's worth of restoring steps, unrolled BITS_PER_CYCLE times.
    // NOTE: blocking assignments here chain each step's remainder into the
    // next step within the same cycle; every variable gets a default first
    // so no latch is inferred.
    always_comb begin
        rem_n = rem_q;
        x_n   = x_q;
        quo_n = quo_q;
        r_sh  = '0;
        trial = '0;
        diff  = '0;
        bit_q = 1'b0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (!(first_grp && j < EXC)) begin
                if (sqrt_q) begin
                    // Bring down the next radicand bit pair, try 4q+1.
                    r_sh  = {rem_n[REM_W-3:0], x_n[X_W-1 -: 2]};
                    trial = {{(REM_W-RES_W-2){1'b0}}, quo_n, 2'b01};
                    bit_q = (r_sh >= trial);
                    rem_n = bit_q ? (r_sh - trial) : r_sh;
                    x_n   = {x_n[X_W-3:0], 2'b00};
                end else begin
                    bit_q = (rem_n >= dvs_ext);
                    diff  = bit_q ? (rem_n - dvs_ext) : rem_n;
                    rem_n = {diff[REM_W-2:0], 1'b0};
                end
                quo_n = {quo_n[RES_W-2:0], bit_q};
            end
        end
    end

    // NOTE: outputs are registered in the FSM block so done/result/sticky
    // change together on the clock edge and stay stable while waiting for ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            x_q      <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            sqrt_q   <= 1'b0;
            id_q     <= '0;
            done     <= 1'b0;
            result   <= '0;
            sticky   <= 1'b0;
            bypassed <= 1'b0;
            id_out   <= '0;
        end else if (flush) begin
            // Flush wins over start: nothing is accepted this cycle.
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    rem_q <= rem_n;
                    x_q   <= x_n;
                    quo_q <= quo_n;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        result   <= quo_n;
                        sticky   <= |rem_n;
                        bypassed <= 1'b0;
                        id_out   <= id_q;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Accept may coincide with ack in DONE; it overrides the retire.
            if (accept) begin
                sqrt_q <= mode_sqrt;
                id_q   <= id_in;
                dvs_q  <= b;
                quo_q  <= '0;
                cnt    <= CNT_W'(ITERS);
                rem_q  <= mode_sqrt ? '0 : {{(REM_W-W){1'b0}}, a};
                x_q    <= expo_odd ? {a, {(FRAC_W+5){1'b0}}}
                                   : {1'b0, a, {(FRAC_W+4){1'b0}}};
                if (bypass) begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    result   <= '0;
                    sticky   <= 1'b0;
                    bypassed <= 1'b1;
                    id_out   <= id_in;
                end else begin
                    state <= S_RUN;
                    done  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_divsqrt_iter.sv
// ---------------------------------------------------------------------------
// tb_fp_divsqrt_iter
//   Three engines with FRAC_W=23 and BITS_PER_CYCLE = 1, 2, 4 side by side.
//   Expected results come from integer division and an integer square root
//   in the bench; latencies from ceil((FRAC_W+3)/BITS_PER_CYCLE)+1.
// ---------------------------------------------------------------------------
module tb_fp_divsqrt_iter;

    localparam int FW = 23;
    localparam int W  = FW + 1;
    localparam int RW = FW + 3;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] start_v, ready_v, mode_v, odd_v, byp_v, flush_v;
    logic [NI-1:0] done_v, ack_v, sticky_v, bypd_v;
    logic [2:0]    id_in_v  [NI];
    logic [2:0]    id_out_v [NI];
    logic [W-1:0]  a_v      [NI];
    logic [W-1:0]  b_v      [NI];
    logic [RW-1:0] res_v    [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fp_divsqrt_iter #(
            .FRAC_W(FW), .BITS_PER_CYCLE(1 << g), .ID_W(3)
        ) u_dut (
            .clk(clk), .rst(rst),
            .start(start_v[g]), .ready(ready_v[g]),
            .mode_sqrt(mode_v[g]), .expo_odd(odd_v[g]), .bypass(byp_v[g]),
            .id_in(id_in_v[g]), .a(a_v[g]), .b(b_v[g]),
            .flush(flush_v[g]), .done(done_v[g]), .ack(ack_v[g]),
            .id_out(id_out_v[g]), .result(res_v[g]),
            .sticky(sticky_v[g]), .bypassed(bypd_v[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical definitions.
    task automatic model(input bit sq, input bit odd, input bit byp,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         output longint res, output bit st);
        longint num, x, r;
        if (byp) begin
            res = 0; st = 0;
        end else if (!sq) begin
            num = longint'(av) << (FW + 2);
            res = num / longint'(bv);
            st  = (num % longint'(bv)) != 0;
        end else begin
            x = longint'(av) << (FW + 4 + int'(odd));
            r = longint'($sqrt(real'(x)));
            while (r * r > x) r--;
            while ((r + 1) * (r + 1) <= x) r++;
            res = r;
            st  = (r * r) != x;
        end
    endtask

    function automatic int exp_lat(input int k, input bit byp);
        int bpc;
        bpc = 1 << k;
        return byp ? 1 : (RW + bpc - 1) / bpc + 1;
    endfunction

    function automatic logic [W-1:0] rnd_sig();
        logic [W-1:0] v;
        v = W'($urandom);
        v[W-1] = 1'b1;
        return v;
    endfunction

    // Issue one op, wait for done (bounded), check everything, hold for
    // ack_delay cycles, then ack. With poke set, a stray start (with other
    // operands) and a stray ack are pulsed mid-run and must be ignored.
    task automatic do_op(input int k, input bit sq, input bit odd, input bit byp,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] idv, input int ack_delay, input bit poke);
        longint er;
        bit     es;
        int     lat;
        model(sq, odd, byp, av, bv, er, es);
        @(negedge clk);
        check($sformatf("k%0d ready_before_start", k), 64'(ready_v[k]), 64'd1);
        mode_v[k] = sq; odd_v[k] = odd; byp_v[k] = byp;
        a_v[k] = av; b_v[k] = bv; id_in_v[k] = idv; start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0; byp_v[k] = 1'b0;
        lat = 1;
        while (!done_v[k] && lat < 100) begin
            if (poke && lat == 5) begin
                start_v[k] = 1'b1; ack_v[k] = 1'b1; mode_v[k] = ~sq;
                a_v[k] = rnd_sig(); b_v[k] = rnd_sig(); id_in_v[k] = ~idv;
            end
            @(negedge clk);
            start_v[k] = 1'b0; ack_v[k] = 1'b0;
            lat++;
        end
        check($sformatf("k%0d latency", k), 64'(lat), 64'(exp_lat(k, byp)));
        check($sformatf("k%0d result", k), 64'(res_v[k]), 64'(er));
        check($sformatf("k%0d sticky", k), 64'(sticky_v[k]), 64'(es));
        check($sformatf("k%0d bypassed", k), 64'(bypd_v[k]), 64'(byp));
        check($sformatf("k%0d id_out", k), 64'(id_out_v[k]), 64'(idv));
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            check($sformatf("k%0d hold_done", k), 64'(done_v[k]), 64'd1);
            check($sformatf("k%0d hold_result", k), 64'(res_v[k]), 64'(er));
        end
        @(negedge clk);
        ack_v[k] = 1'b1;
        @(negedge clk);
        ack_v[k] = 1'b0;
        check($sformatf("k%0d done_after_ack", k), 64'(done_v[k]), 64'd0);
    endtask

    // Watch for n cycles that done never rises.
    task automatic expect_quiet(input int k, input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done_v[k]) seen = 1'b1;
        end
        check($sformatf("k%0d %s", k, tag), 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        start_v = '0; mode_v = '0; odd_v = '0; byp_v = '0; flush_v = '0; ack_v = '0;
        for (int k = 0; k < NI; k++) begin
            id_in_v[k] = '0; a_v[k] = '0; b_v[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        for (int k = 0; k < NI; k++) begin
            check($sformatf("k%0d rst_done", k), 64'(done_v[k]), 64'd0);
            check($sformatf("k%0d rst_ready", k), 64'(ready_v[k]), 64'd1);
            check($sformatf("k%0d rst_result", k), 64'(res_v[k]), 64'd0);
            check($sformatf("k%0d rst_sticky", k), 64'(sticky_v[k]), 64'd0);
            check($sformatf("k%0d rst_bypassed", k), 64'(bypd_v[k]), 64'd0);
            check($sformatf("k%0d rst_id", k), 64'(id_out_v[k]), 64'd0);
        end

        for (int k = 0; k < NI; k++) begin
            // Directed operand cases
            do_op(k, 0, 0, 0, 24'h800000, 24'h800000, 3'd1, 0, 0);
            do_op(k, 0, 0, 0, 24'h800000, 24'hC00000, 3'd2, 0, 0);
            do_op(k, 1, 0, 0, 24'h800000, 24'h000000, 3'd3, 0, 0);
            do_op(k, 1, 1, 0, 24'h800000, 24'h000000, 3'd4, 0, 0);
            do_op(k, 0, 0, 0, 24'hFFFFFF, 24'h800000, 3'd5, 0, 0);
            do_op(k, 0, 0, 0, 24'h800000, 24'hFFFFFF, 3'd6, 0, 0);
            do_op(k, 1, 1, 0, 24'hFFFFFF, 24'h000000, 3'd7, 0, 0);

            // Bypass, held 10 cycles, then ack+start in the same cycle.
            @(negedge clk);
            byp_v[k] = 1'b1; id_in_v[k] = 3'd5; a_v[k] = rnd_sig(); start_v[k] = 1'b1;
            @(negedge clk);
            start_v[k] = 1'b0; byp_v[k] = 1'b0;
            check($sformatf("k%0d byp_done", k), 64'(done_v[k]), 64'd1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check($sformatf("k%0d byp_hold_done", k), 64'(done_v[k]), 64'd1);
                check($sformatf("k%0d byp_hold_flag", k), 64'(bypd_v[k]), 64'd1);
                check($sformatf("k%0d byp_hold_id", k), 64'(id_out_v[k]), 64'd5);
                check($sformatf("k%0d byp_hold_result", k), 64'(res_v[k]), 64'd0);
                check($sformatf("k%0d byp_hold_sticky", k), 64'(sticky_v[k]), 64'd0);
            end
            mode_v[k] = 1'b0; odd_v[k] = 1'b0; a_v[k] = 24'h800000; b_v[k] = 24'hC00000;
            id_in_v[k] = 3'd6; start_v[k] = 1'b1; ack_v[k] = 1'b1;
            #1;
            check($sformatf("k%0d b2b_ready", k), 64'(ready_v[k]), 64'd1);
            @(negedge clk);
            start_v[k] = 1'b0; ack_v[k] = 1'b0;
            check($sformatf("k%0d b2b_retired", k), 64'(done_v[k]), 64'd0);
            lat = 1;
            while (!done_v[k] && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("k%0d b2b_latency", k), 64'(lat), 64'(exp_lat(k, 0)));
            check($sformatf("k%0d b2b_result", k), 64'(res_v[k]), 64'h1555555);
            check($sformatf("k%0d b2b_sticky", k), 64'(sticky_v[k]), 64'd1);
            check($sformatf("k%0d b2b_id", k), 64'(id_out_v[k]), 64'd6);
            check($sformatf("k%0d b2b_bypassed", k), 64'(bypd_v[k]), 64'd0);
            ack_v[k] = 1'b1;
            @(negedge clk);
            ack_v[k] = 1'b0;

            // Flush 10 cycles into RUN, then the same op again.
            a_v[k] = 24'h800000; b_v[k] = 24'hC00000; mode_v[k] = 1'b0; start_v[k] = 1'b1;
            @(negedge clk);
            start_v[k] = 1'b0;
            repeat (10) @(negedge clk);
            flush_v[k] = 1'b1;
            @(negedge clk);
            flush_v[k] = 1'b0;
            check($sformatf("k%0d flush_ready", k), 64'(ready_v[k]), 64'd1);
            expect_quiet(k, 40, "flush_no_done");
            do_op(k, 0, 0, 0, 24'h800000, 24'hC00000, 3'd2, 0, 0);

            // Flush beats start in the same cycle.
            @(negedge clk);
            start_v[k] = 1'b1; flush_v[k] = 1'b1;
            @(negedge clk);
            start_v[k] = 1'b0; flush_v[k] = 1'b0;
            check($sformatf("k%0d flush_beats_start", k), 64'(ready_v[k]), 64'd1);
            expect_quiet(k, 40, "flush_start_no_done");

            // Stray start/ack while busy are ignored.
            do_op(k, 0, 0, 0, 24'h9ABCDE, 24'hC12345, 3'd3, 0, 1);
            do_op(k, 1, 1, 0, 24'hB00001, 24'h000000, 3'd4, 2, 1);

            // Randomised operations
            for (int n = 0; n < 30; n++) begin
                do_op(k, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                      rnd_sig(), rnd_sig(), 3'($urandom), $urandom_range(0, 3), 1'($urandom));
            end
        end

        // Reset mid-RUN on the BITS_PER_CYCLE=1 engine.
        @(negedge clk);
        mode_v[0] = 1'b1; odd_v[0] = 1'b1; a_v[0] = 24'h800000; id_in_v[0] = 3'd7; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("k0 midrst_done", 64'(done_v[0]), 64'd0);
        check("k0 midrst_ready", 64'(ready_v[0]), 64'd1);
        check("k0 midrst_result", 64'(res_v[0]), 64'd0);
        check("k0 midrst_id", 64'(id_out_v[0]), 64'd0);
        expect_quiet(0, 40, "midrst_no_done");
        do_op(0, 1, 0, 0, 24'h800000, 24'h000000, 3'd1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
